// File: rtl/group_table_update_engine_if.sv
// Command, response and table-port bundle for one group table update engine.
interface group_table_update_engine_if #(
   parameter int unsigned KEY_W = 104
);
   localparam int unsigned ENTRY_W = 1 + 11 + 11 + KEY_W;

   logic               cmd_valid;
   logic               cmd_ready;
   logic               cmd_op;
   logic [10:0]        cmd_head_index;
   logic [10:0]        cmd_ruleID;
   logic [KEY_W-1:0]   cmd_key;
   logic               rsp_valid;
   logic [1:0]         rsp_status;
   logic [10:0]        rsp_index;
   logic               rsp_new_head;
   logic [10:0]        used_count;
   logic               mem_rd_en;
   logic [10:0]        mem_rd_addr;
   logic [ENTRY_W-1:0] mem_rd_data;
   logic               mem_wr_en;
   logic [10:0]        mem_wr_addr;
   logic [ENTRY_W-1:0] mem_wr_data;

   modport slave (
      input  cmd_valid, cmd_op, cmd_head_index, cmd_ruleID, cmd_key, mem_rd_data,
      output cmd_ready, rsp_valid, rsp_status, rsp_index, rsp_new_head, used_count,
             mem_rd_en, mem_rd_addr, mem_wr_en, mem_wr_addr, mem_wr_data
   );

   modport master (
      output cmd_valid, cmd_op, cmd_head_index, cmd_ruleID, cmd_key, mem_rd_data,
      input  cmd_ready, rsp_valid, rsp_status, rsp_index, rsp_new_head, used_count,
             mem_rd_en, mem_rd_addr, mem_wr_en, mem_wr_addr, mem_wr_data
   );
endinterface

// File: rtl/group_table_update_engine.sv
// Insert/delete engine for one group table's linked-list buckets; owns the
// table write port and a second read port.
module group_table_update_engine #(
   parameter int unsigned TABLE_ENTRY_SIZE = 1738,
   parameter int unsigned KEY_W            = 104
) (
   input logic                          clk,
   input logic                          rst,
   group_table_update_engine_if.slave   bus
);
   localparam int unsigned       ENTRY_W    = 1 + 11 + 11 + KEY_W;
   localparam int unsigned       STEP_W     = $clog2(TABLE_ENTRY_SIZE + 2);
   localparam logic [10:0]       NULL_INDEX = 11'h7FF;
   localparam logic [10:0]       TABLE_SIZE = 11'(TABLE_ENTRY_SIZE);
   localparam logic [STEP_W-1:0] STEP_LIMIT = STEP_W'(TABLE_ENTRY_SIZE);

   typedef enum logic [2:0] {
      S_IDLE, S_RD_REQ, S_RD_WAIT, S_WR_NEW, S_WR_LINK, S_WR_DEL, S_RESP
   } state_e;

   typedef enum logic [1:0] {
      ST_OK = 2'd0, ST_FULL = 2'd1, ST_NOT_FOUND = 2'd2, ST_CHAIN_ERR = 2'd3
   } status_e;

   state_e              state_q, state_d;
   logic                op_q, op_d;
   logic [10:0]         rule_q, rule_d;
   logic [KEY_W-1:0]    key_q, key_d;
   logic [10:0]         cur_q, cur_d;
   logic [10:0]         new_slot_q, new_slot_d;
   logic                empty_q, empty_d;
   logic [ENTRY_W-1:0]  entry_q, entry_d;
   logic [STEP_W-1:0]   step_q, step_d;
   logic [10:0]         used_q, used_d;
   logic                rsp_valid_q, rsp_valid_d;
   status_e             rsp_status_q, rsp_status_d;
   logic [10:0]         rsp_index_q, rsp_index_d;
   logic                rsp_new_head_q, rsp_new_head_d;

   logic                rd_valid;
   logic [10:0]         rd_rule;
   logic [10:0]         rd_next;

   assign rd_valid = bus.mem_rd_data[ENTRY_W-1];
   assign rd_rule  = bus.mem_rd_data[KEY_W+11 +: 11];
   assign rd_next  = bus.mem_rd_data[KEY_W +: 11];

   always_comb begin
      state_d        = state_q;
      op_d           = op_q;
      rule_d         = rule_q;
      key_d          = key_q;
      cur_d          = cur_q;
      new_slot_d     = new_slot_q;
      empty_d        = empty_q;
      entry_d        = entry_q;
      step_d         = step_q;
      used_d         = used_q;
      rsp_valid_d    = 1'b0;
      rsp_status_d   = ST_OK;
      rsp_index_d    = NULL_INDEX;
      rsp_new_head_d = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (bus.cmd_valid) begin
               op_d    = bus.cmd_op;
               rule_d  = bus.cmd_ruleID;
               key_d   = bus.cmd_key;
               cur_d   = bus.cmd_head_index;
               empty_d = (bus.cmd_head_index == NULL_INDEX);
               step_d  = '0;
               if (!bus.cmd_op && used_q == TABLE_SIZE) begin
                  state_d      = S_RESP;
                  rsp_valid_d  = 1'b1;
                  rsp_status_d = ST_FULL;
               end else if (!bus.cmd_op && bus.cmd_head_index == NULL_INDEX) begin
                  state_d = S_WR_NEW;
               end else begin
                  state_d = S_RD_REQ;
               end
            end
         end
         S_RD_REQ: begin
            step_d  = step_q + 1'b1;
            state_d = S_RD_WAIT;
         end
         S_RD_WAIT: begin
            // cur_q stays on the entry just read: it becomes the tail or the hit slot.
            entry_d = bus.mem_rd_data;
            if (step_q > STEP_LIMIT) begin
               state_d      = S_RESP;
               rsp_valid_d  = 1'b1;
               rsp_status_d = ST_CHAIN_ERR;
            end else if (!op_q) begin
               if (rd_next == NULL_INDEX) begin
                  state_d = S_WR_NEW;
               end else begin
                  cur_d   = rd_next;
                  state_d = S_RD_REQ;
               end
            end else if (rd_valid && rd_rule == rule_q) begin
               state_d = S_WR_DEL;
            end else if (rd_next == NULL_INDEX) begin
               state_d      = S_RESP;
               rsp_valid_d  = 1'b1;
               rsp_status_d = ST_NOT_FOUND;
            end else begin
               cur_d   = rd_next;
               state_d = S_RD_REQ;
            end
         end
         S_WR_NEW: begin
            new_slot_d = used_q;
            if (used_q != TABLE_SIZE) used_d = used_q + 11'd1;
            if (empty_q) begin
               state_d        = S_RESP;
               rsp_valid_d    = 1'b1;
               rsp_index_d    = used_q;
               rsp_new_head_d = 1'b1;
            end else begin
               state_d = S_WR_LINK;
            end
         end
         S_WR_LINK: begin
            state_d     = S_RESP;
            rsp_valid_d = 1'b1;
            rsp_index_d = new_slot_q;
         end
         S_WR_DEL: begin
            state_d     = S_RESP;
            rsp_valid_d = 1'b1;
            rsp_index_d = cur_q;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q        <= S_IDLE;
         op_q           <= 1'b0;
         rule_q         <= '0;
         key_q          <= '0;
         cur_q          <= NULL_INDEX;
         new_slot_q     <= '0;
         empty_q        <= 1'b0;
         entry_q        <= '0;
         step_q         <= '0;
         used_q         <= '0;
         rsp_valid_q    <= 1'b0;
         rsp_status_q   <= ST_OK;
         rsp_index_q    <= NULL_INDEX;
         rsp_new_head_q <= 1'b0;
      end else begin
         state_q        <= state_d;
         op_q           <= op_d;
         rule_q         <= rule_d;
         key_q          <= key_d;
         cur_q          <= cur_d;
         new_slot_q     <= new_slot_d;
         empty_q        <= empty_d;
         entry_q        <= entry_d;
         step_q         <= step_d;
         used_q         <= used_d;
         rsp_valid_q    <= rsp_valid_d;
         rsp_status_q   <= rsp_status_d;
         rsp_index_q    <= rsp_index_d;
         rsp_new_head_q <= rsp_new_head_d;
      end
   end

   assign bus.cmd_ready    = (state_q == S_IDLE) && !rst;
   assign bus.rsp_valid    = rsp_valid_q;
   assign bus.rsp_status   = rsp_status_q;
   assign bus.rsp_index    = rsp_index_q;
   assign bus.rsp_new_head = rsp_new_head_q;
   assign bus.used_count   = used_q;
   assign bus.mem_rd_en    = (state_q == S_RD_REQ) && !rst;
   assign bus.mem_rd_addr  = cur_q;
   assign bus.mem_wr_en    = (state_q == S_WR_NEW || state_q == S_WR_LINK ||
                              state_q == S_WR_DEL) && !rst;
   assign bus.mem_wr_addr  = (state_q == S_WR_NEW) ? used_q : cur_q;

   always_comb begin
      bus.mem_wr_data = {1'b1, rule_q, NULL_INDEX, key_q};
      case (state_q)
         S_WR_LINK: bus.mem_wr_data = {entry_q[ENTRY_W-1 -: 12], new_slot_q, entry_q[KEY_W-1:0]};
         S_WR_DEL:  bus.mem_wr_data = {1'b0, entry_q[ENTRY_W-2:0]};
         default:   ;
      endcase
   end
endmodule

// File: tb/tb_group_table_update_engine.sv
// Self-checking bench: vector table plus scoreboards for responses and table writes.
module tb_group_table_update_engine;
   localparam int          T       = 4;
   localparam int          KEY_W   = 104;
   localparam int          ENTRY_W = 23 + KEY_W;
   localparam logic [10:0] NULLI   = 11'h7FF;

   typedef struct {
      bit          op;
      logic [10:0] head;
      logic [10:0] rule;
      logic [KEY_W-1:0] key;
      logic [1:0]  st;
      logic [10:0] idx;
      logic        nh;
      int          lat;
      logic [10:0] used;
      int          nrd;
   } vec_t;

   typedef struct {
      logic [1:0]  st;
      logic [10:0] idx;
      logic        nh;
      int          lat;
      int          hs;
   } rsp_t;

   typedef struct {
      logic [10:0]        addr;
      logic [ENTRY_W-1:0] data;
   } wr_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   tests = 0;
   int   fails = 0;
   int   cyc   = 0;
   int   rd_seen = 0;
   int   wr_seen = 0;
   bit   chk_wr  = 1'b1;

   rsp_t eq[$];
   wr_t  wq[$];
   logic [ENTRY_W-1:0] ref_mem [0:2047];
   int   model_used = 0;

   logic [ENTRY_W-1:0] mem [0:2047];
   logic [ENTRY_W-1:0] rd_data_q;
   logic               pre_en = 1'b0;
   logic [10:0]        pre_addr = '0;
   logic [ENTRY_W-1:0] pre_data = '0;

   group_table_update_engine_if #(.KEY_W(KEY_W)) bus ();

   group_table_update_engine #(
      .TABLE_ENTRY_SIZE(T),
      .KEY_W(KEY_W)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   always @(posedge clk) begin
      if (pre_en) mem[pre_addr] <= pre_data;
      if (bus.mem_wr_en) mem[bus.mem_wr_addr] <= bus.mem_wr_data;
      if (bus.mem_rd_en) rd_data_q <= mem[bus.mem_rd_addr];
   end
   assign bus.mem_rd_data = rd_data_q;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   always @(negedge clk) begin
      rsp_t r;
      wr_t  w;
      if (bus.mem_rd_en) rd_seen++;
      if (bus.mem_wr_en) begin
         wr_seen++;
         if (chk_wr) begin
            if (wq.size() == 0) begin
               chk("unexpected_write_addr", {117'd0, bus.mem_wr_addr}, {117'd0, NULLI});
            end else begin
               w = wq.pop_front();
               chk("wr_addr", {117'd0, bus.mem_wr_addr}, {117'd0, w.addr});
               chk("wr_data", {1'b0, bus.mem_wr_data}, {1'b0, w.data});
            end
         end
      end
      if (bus.rsp_valid) begin
         if (eq.size() == 0) begin
            chk("unexpected_rsp", {127'd0, bus.rsp_valid}, 128'd0);
         end else begin
            r = eq.pop_front();
            chk("rsp_status", {126'd0, bus.rsp_status}, {126'd0, r.st});
            chk("rsp_index", {117'd0, bus.rsp_index}, {117'd0, r.idx});
            chk("rsp_new_head", {127'd0, bus.rsp_new_head}, {127'd0, r.nh});
            chk("rsp_latency", 128'(cyc - r.hs + 1), 128'(r.lat));
         end
      end
   end

   function automatic logic [KEY_W-1:0] mk_key(input int n);
      logic [7:0] b;
      b = 8'(n * 37 + 11);
      return {13{b}};
   endfunction

   function automatic vec_t mkv(input bit op, input logic [10:0] head, input logic [10:0] rule,
                                input int k, input logic [1:0] st, input logic [10:0] idx,
                                input logic nh, input int lat, input logic [10:0] used, input int nrd);
      vec_t v;
      v.op = op; v.head = head; v.rule = rule; v.key = mk_key(k);
      v.st = st; v.idx = idx; v.nh = nh; v.lat = lat; v.used = used; v.nrd = nrd;
      return v;
   endfunction

   // Reference behaviour of the table: predicts the writes a command must issue.
   task automatic model_cmd(input vec_t v, output int nwr);
      logic [10:0]        cur;
      logic [ENTRY_W-1:0] e;
      int                 reads;
      nwr   = 0;
      cur   = v.head;
      reads = 0;
      if (!v.op) begin
         if (model_used == T) return;
         if (v.head != NULLI) begin
            forever begin
               reads++;
               if (reads > T) return;
               e = ref_mem[cur];
               if (e[KEY_W +: 11] == NULLI) break;
               cur = e[KEY_W +: 11];
            end
         end
         wq.push_back('{11'(model_used), {1'b1, v.rule, NULLI, v.key}});
         ref_mem[model_used] = {1'b1, v.rule, NULLI, v.key};
         nwr = 1;
         if (v.head != NULLI) begin
            e[KEY_W +: 11] = 11'(model_used);
            wq.push_back('{cur, e});
            ref_mem[cur] = e;
            nwr = 2;
         end
         model_used++;
      end else begin
         forever begin
            reads++;
            if (reads > T) return;
            e = ref_mem[cur];
            if (e[ENTRY_W-1] && e[KEY_W+11 +: 11] == v.rule) begin
               e[ENTRY_W-1] = 1'b0;
               wq.push_back('{cur, e});
               ref_mem[cur] = e;
               nwr = 1;
               return;
            end
            if (e[KEY_W +: 11] == NULLI) return;
            cur = e[KEY_W +: 11];
         end
      end
   endtask

   task automatic run_cmd(input vec_t v);
      int nwr;
      model_cmd(v, nwr);
      @(negedge clk);
      rd_seen = 0;
      wr_seen = 0;
      chk("cmd_ready_idle", {127'd0, bus.cmd_ready}, 128'd1);
      bus.cmd_valid      = 1'b1;
      bus.cmd_op         = v.op;
      bus.cmd_head_index = v.head;
      bus.cmd_ruleID     = v.rule;
      bus.cmd_key        = v.key;
      @(posedge clk);
      eq.push_back('{v.st, v.idx, v.nh, v.lat, cyc + 1});
      #1 bus.cmd_valid = 1'b0;
      for (int i = 0; i < 100 && eq.size() != 0; i++) @(negedge clk);
      if (eq.size() != 0) begin
         chk("rsp_timeout", 128'(eq.size()), 128'd0);
         eq.delete();
      end
      @(negedge clk);
      chk("used_count", {117'd0, bus.used_count}, {117'd0, v.used});
      chk("write_count", 128'(wr_seen), 128'(nwr));
      chk("read_count", 128'(rd_seen), 128'(v.nrd));
      chk("writes_left", 128'(wq.size()), 128'd0);
      wq.delete();
   endtask

   task automatic preload(input logic [10:0] a, input logic [ENTRY_W-1:0] d);
      @(negedge clk);
      pre_en   = 1'b1;
      pre_addr = a;
      pre_data = d;
      ref_mem[a] = d;
      @(posedge clk);
      #1 pre_en = 1'b0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      model_used = 0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      vec_t vt[9];
      bus.cmd_valid = 1'b0;
      bus.cmd_op = 1'b0;
      bus.cmd_head_index = NULLI;
      bus.cmd_ruleID = '0;
      bus.cmd_key = '0;
      for (int unsigned i = 0; i < 2048; i++) ref_mem[i] = '0;

      //         op head   rule k  st  idx    nh lat used nrd
      vt[0] = mkv(0, NULLI, 5,   1, 0, 11'd0, 1, 2, 1, 0);
      vt[1] = mkv(0, 11'd0, 9,   2, 0, 11'd1, 0, 5, 2, 1);
      vt[2] = mkv(0, 11'd0, 12,  3, 0, 11'd2, 0, 7, 3, 2);
      vt[3] = mkv(1, 11'd0, 9,   0, 0, 11'd1, 0, 6, 3, 2);
      vt[4] = mkv(1, 11'd0, 9,   0, 2, NULLI, 0, 7, 3, 3);
      vt[5] = mkv(0, NULLI, 20,  4, 0, 11'd3, 1, 2, 4, 0);
      vt[6] = mkv(0, NULLI, 21,  5, 1, NULLI, 0, 1, 4, 0);
      vt[7] = mkv(1, 11'd0, 5,   0, 0, 11'd0, 0, 4, 4, 1);
      vt[8] = mkv(1, 11'd0, 5,   0, 2, NULLI, 0, 7, 4, 3);

      repeat (2) @(negedge clk);
      chk("rst_cmd_ready", {127'd0, bus.cmd_ready}, 128'd0);
      chk("rst_mem_rd_en", {127'd0, bus.mem_rd_en}, 128'd0);
      chk("rst_mem_wr_en", {127'd0, bus.mem_wr_en}, 128'd0);
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("rst_rsp_valid", {127'd0, bus.rsp_valid}, 128'd0);
      chk("rst_rsp_status", {126'd0, bus.rsp_status}, 128'd0);
      chk("rst_rsp_index", {117'd0, bus.rsp_index}, {117'd0, NULLI});
      chk("rst_rsp_new_head", {127'd0, bus.rsp_new_head}, 128'd0);
      chk("rst_used_count", {117'd0, bus.used_count}, 128'd0);
      chk("rst_cmd_ready_rel", {127'd0, bus.cmd_ready}, 128'd1);

      for (int i = 0; i < 9; i++) run_cmd(vt[i]);

      // Looped chain: slot 0 points to itself.
      do_reset();
      preload(11'd0, {1'b1, 11'd1, 11'd0, mk_key(9)});
      run_cmd(mkv(0, 11'd0, 30, 6, 3, NULLI, 0, 2 * (T + 1) + 1, 0, T + 1));

      // Reset while the link write is pending.
      do_reset();
      preload(11'd0, {1'b1, 11'd5, NULLI, mk_key(7)});
      chk_wr = 1'b0;
      @(negedge clk);
      bus.cmd_valid      = 1'b1;
      bus.cmd_op         = 1'b0;
      bus.cmd_head_index = 11'd0;
      bus.cmd_ruleID     = 11'd40;
      bus.cmd_key        = mk_key(8);
      @(posedge clk);
      #1 bus.cmd_valid = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b1;
      wr_seen = 0;
      @(negedge clk);
      chk("wr_link_rst_wr_en", {127'd0, bus.mem_wr_en}, 128'd0);
      chk("wr_link_rst_rsp", {127'd0, bus.rsp_valid}, 128'd0);
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("wr_link_rst_ready", {127'd0, bus.cmd_ready}, 128'd1);
      chk("wr_link_rst_used", {117'd0, bus.used_count}, 128'd0);
      chk("wr_link_rst_writes", 128'(wr_seen), 128'd0);
      repeat (3) @(negedge clk);
      chk_wr = 1'b1;

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
